// File: rtl/led_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_multi
// Description : Multi-channel millisecond-resolution LED PWM with per-channel
//               period/on-time, enable, invert, and an Avalon-MM pipelined
//               slave register file (CTRL at 0, CHi at 1+i).
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_multi #(
    parameter int CLOCK_FREQ_MHZ = 25,
    parameter int CLKS_PER_MS    = CLOCK_FREQ_MHZ * 1000,
    parameter int LED_CNT        = 4,
    parameter int PERIOD_MIN_MS  = 32,
    parameter int ADDR_W         = $clog2(LED_CNT + 1)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [ADDR_W-1:0] amm_address_i,
    input  logic [31:0]       amm_writedata_i,
    input  logic              amm_read_i,
    input  logic              amm_write_i,
    output logic [31:0]       amm_readdata_o,
    output logic              amm_readdatavalid_o,
    output logic              amm_waitrequest_o,
    output logic [LED_CNT-1:0] led_o
);

    localparam int                    c_PRESC_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [c_PRESC_W-1:0]  c_PRESC_LAST = c_PRESC_W'(CLKS_PER_MS - 1);
    localparam logic [15:0]           c_PER_MIN    = 16'(PERIOD_MIN_MS);
    localparam logic [15:0]           c_RST_PERIOD = 16'd500;
    localparam logic [15:0]           c_RST_ON     = 16'd250;
    // Shadow reset values are the clamped form of the register reset values
    localparam logic [15:0]           c_RST_SH_PER = (c_RST_PERIOD < c_PER_MIN) ? c_PER_MIN : c_RST_PERIOD;
    localparam logic [15:0]           c_RST_SH_ON  = (c_RST_ON > c_RST_SH_PER) ? c_RST_SH_PER : c_RST_ON;
    // Invert bit 15 shares CTRL bit 31 with RESTART, so it is never writable
    localparam logic [LED_CNT-1:0]    c_INV_MASK   = LED_CNT'(32'h0000_7FFF);

    logic [c_PRESC_W-1:0]       r_presc;
    logic                       w_tick;
    logic [LED_CNT-1:0]         r_enable;
    logic [LED_CNT-1:0]         r_invert;
    logic [LED_CNT-1:0]         r_led;
    logic [LED_CNT-1:0][15:0]   r_period;
    logic [LED_CNT-1:0][15:0]   r_on;
    logic [LED_CNT-1:0][15:0]   r_cnt;
    logic [LED_CNT-1:0][15:0]   r_sh_per;
    logic [LED_CNT-1:0][15:0]   r_sh_on;
    logic [LED_CNT-1:0][15:0]   w_eff_per;
    logic [LED_CNT-1:0][15:0]   w_eff_on;
    logic                       w_wr_ctrl;
    logic                       w_restart;
    logic [LED_CNT-1:0]         w_wr_ch;
    logic [31:0]                w_rd_data;
    logic [31:0]                r_rd_data;
    logic                       r_rd_valid;

    assign w_tick = (r_presc == c_PRESC_LAST);

    // Write address decode and RESTART strobe detection
    always_comb begin
        w_wr_ctrl = amm_write_i && (amm_address_i == '0);
        w_restart = w_wr_ctrl && amm_writedata_i[31];
        w_wr_ch   = '0;
        for (int i = 0; i < LED_CNT; i++) begin
            w_wr_ch[i] = amm_write_i && (amm_address_i == ADDR_W'(i + 1));
        end
    end

    // Effective period/on-time: period clamped from below, on-time capped at period
    always_comb begin
        w_eff_per = '0;
        w_eff_on  = '0;
        for (int i = 0; i < LED_CNT; i++) begin
            w_eff_per[i] = (r_period[i] < c_PER_MIN) ? c_PER_MIN : r_period[i];
            w_eff_on[i]  = (r_on[i] > w_eff_per[i]) ? w_eff_per[i] : r_on[i];
        end
    end

    // Read data mux; unmapped addresses and unimplemented bits read as zero
    always_comb begin
        w_rd_data = '0;
        if (amm_address_i == '0) begin
            w_rd_data[LED_CNT-1:0]  = r_enable;
            w_rd_data[16 +: LED_CNT] = r_invert;
        end
        for (int i = 0; i < LED_CNT; i++) begin
            if (amm_address_i == ADDR_W'(i + 1)) begin
                w_rd_data = {r_on[i], r_period[i]};
            end
        end
    end

    // Software-visible register file
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_enable <= '1;
            r_invert <= '0;
            for (int i = 0; i < LED_CNT; i++) begin
                r_period[i] <= c_RST_PERIOD;
                r_on[i]     <= c_RST_ON;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= amm_writedata_i[LED_CNT-1:0];
                r_invert <= amm_writedata_i[16 +: LED_CNT] & c_INV_MASK;
            end
            for (int i = 0; i < LED_CNT; i++) begin
                if (w_wr_ch[i]) begin
                    r_on[i]     <= amm_writedata_i[31:16];
                    r_period[i] <= amm_writedata_i[15:0];
                end
            end
        end
    end

    // Millisecond prescaler; RESTART realigns it with the channel counters
    always_ff @(posedge clk_i) begin
        if (srst_i || w_restart) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    // Channel counters with shadowed period/on-time, reloaded only at period boundaries
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < LED_CNT; i++) begin
                r_cnt[i]    <= '0;
                r_sh_per[i] <= c_RST_SH_PER;
                r_sh_on[i]  <= c_RST_SH_ON;
            end
        end else begin
            for (int i = 0; i < LED_CNT; i++) begin
                if (w_restart || !r_enable[i]) begin
                    r_cnt[i]    <= '0;
                    r_sh_per[i] <= w_eff_per[i];
                    r_sh_on[i]  <= w_eff_on[i];
                end else if (w_tick) begin
                    if (r_cnt[i] == r_sh_per[i] - 16'd1) begin
                        r_cnt[i]    <= '0;
                        r_sh_per[i] <= w_eff_per[i];
                        r_sh_on[i]  <= w_eff_on[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 16'd1;
                    end
                end
            end
        end
    end

    // Registered LED drive, one clock behind the counters
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_led <= '0;
        end else begin
            for (int i = 0; i < LED_CNT; i++) begin
                r_led[i] <= (r_enable[i] && (r_cnt[i] < r_sh_on[i])) ^ r_invert[i];
            end
        end
    end

    // Pipelined read response: one valid cycle per read, one clock later
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= amm_read_i;
            r_rd_data  <= amm_read_i ? w_rd_data : '0;
        end
    end

    assign amm_readdata_o      = r_rd_data;
    assign amm_readdatavalid_o = r_rd_valid;
    assign amm_waitrequest_o   = 1'b0;
    assign led_o               = r_led;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_multi
// Description : Self-checking bench for led_pwm_multi: directed steps plus
//               randomized bus traffic against a time-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_multi;

    localparam int CLKS = 4;
    localparam int N    = 4;
    localparam int AW   = 3;

    logic          clk   = 1'b0;
    logic          srst  = 1'b1;
    logic [AW-1:0] addr  = '0;
    logic [31:0]   wdata = '0;
    logic          rd    = 1'b0;
    logic          wr    = 1'b0;
    logic [31:0]   rdata;
    logic          rdv;
    logic          wreq;
    logic [N-1:0]  led;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    led_pwm_multi #(
        .CLKS_PER_MS (CLKS),
        .LED_CNT     (N)
    ) u_dut (
        .clk_i               (clk),
        .srst_i              (srst),
        .amm_address_i       (addr),
        .amm_writedata_i     (wdata),
        .amm_read_i          (rd),
        .amm_write_i         (wr),
        .amm_readdata_o      (rdata),
        .amm_readdatavalid_o (rdv),
        .amm_waitrequest_o   (wreq),
        .led_o               (led)
    );

    // Reference model: time is tracked as elapsed milliseconds since alignment;
    // each channel remembers the ms at which its current period began.
    logic [N-1:0] m_en, m_inv, m_led;
    logic [15:0]  m_per [N];
    logic [15:0]  m_on  [N];
    int           m_sp [N];
    int           m_so [N];
    int           m_start [N];
    int           m_pc, m_ms;
    bit           m_tick, m_restart;
    logic         m_rdv;
    logic [31:0]  m_rd;

    function automatic int effp(input logic [15:0] p);
        return (p < 32) ? 32 : int'(p);
    endfunction

    function automatic int effo(input logic [15:0] o, input logic [15:0] p);
        return (int'(o) < effp(p)) ? int'(o) : effp(p);
    endfunction

    function automatic logic [31:0] regval(input int a);
        if (a == 0) return {12'h0, m_inv, 12'h0, m_en};
        if (a <= N) return {m_on[a-1], m_per[a-1]};
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            m_pc = 0; m_ms = 0; m_en = '1; m_inv = '0; m_led = '0;
            m_rdv = 1'b0; m_rd = '0;
            for (int i = 0; i < N; i++) begin
                m_per[i] = 16'd500; m_on[i] = 16'd250;
                m_sp[i] = 500; m_so[i] = 250; m_start[i] = 0;
            end
        end else begin
            m_rdv = rd;
            m_rd  = rd ? regval(int'(addr)) : 32'h0;
            for (int i = 0; i < N; i++)
                m_led[i] = (m_en[i] && ((m_ms - m_start[i]) < m_so[i])) ^ m_inv[i];
            m_restart = wr && (addr == 0) && wdata[31];
            m_tick    = (m_pc == CLKS - 1);
            if (m_restart) begin
                m_pc = 0;
                for (int i = 0; i < N; i++) begin
                    m_start[i] = m_ms; m_sp[i] = effp(m_per[i]); m_so[i] = effo(m_on[i], m_per[i]);
                end
            end else begin
                m_pc = m_tick ? 0 : m_pc + 1;
                if (m_tick) m_ms++;
                for (int i = 0; i < N; i++) begin
                    if (!m_en[i] || (m_ms - m_start[i] == m_sp[i])) begin
                        m_start[i] = m_ms; m_sp[i] = effp(m_per[i]); m_so[i] = effo(m_on[i], m_per[i]);
                    end
                end
            end
            if (wr) begin
                if (addr == 0) begin
                    m_en  = wdata[N-1:0];
                    m_inv = wdata[16 +: N];
                end else if (int'(addr) <= N) begin
                    m_per[addr-1] = wdata[15:0];
                    m_on[addr-1]  = wdata[31:16];
                end
            end
        end
    end

    // Continuous comparison of the DUT against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            assert (led === m_led) else begin
                n_err++; $error("FAIL led obs=%b exp=%b t=%0t", led, m_led, $time);
            end
            n_chk++;
            assert (rdv === m_rdv) else begin
                n_err++; $error("FAIL rdvalid obs=%b exp=%b t=%0t", rdv, m_rdv, $time);
            end
            if (m_rdv) begin
                n_chk++;
                assert (rdata === m_rd) else begin
                    n_err++; $error("FAIL rdata obs=%h exp=%h t=%0t", rdata, m_rd, $time);
                end
            end
            n_chk++;
            assert (wreq === 1'b0) else begin
                n_err++; $error("FAIL waitreq obs=%b exp=0", wreq);
            end
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check32({tag, "_valid"}, {31'b0, rdv}, 32'd1);
        check32(tag, rdata, exp);
    endtask

    task automatic count_high(input int bit_i, input int ncyc, output int hi);
        hi = 0;
        for (int k = 0; k < ncyc; k++) begin
            hi += int'(led[bit_i]);
            @(negedge clk);
        end
    endtask

    initial begin
        int hi, hi1;

        // Reset state
        srst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check32("rst_led", {28'b0, led}, 32'h0);
        check32("rst_rdv", {31'b0, rdv}, 32'h0);
        check32("rst_rdata", rdata, 32'h0);
        srst = 1'b0;

        // Default 500/250 timing
        rd_chk(3'd1, 32'h00FA_01F4, "rd_ch0_rst");
        count_high(0, 2000, hi);
        check32("ch0_default_high", hi, 1000);

        // Clamped period and saturated on-time
        bus_wr(3'd1, 32'h0005_0010);
        bus_wr(3'd2, 32'h0040_0030);
        repeat (2100) @(negedge clk);
        bus_wr(3'd0, 32'h8000_000F);
        @(negedge clk);
        hi = 0; hi1 = 0;
        for (int k = 0; k < 128; k++) begin
            hi += int'(led[0]); hi1 += int'(led[1]);
            @(negedge clk);
        end
        check32("ch0_clamped_high", hi, 20);
        check32("ch1_always_on", hi1, 128);

        // Mid-period write on channel 2 takes effect only at the next period
        bus_wr(3'd0, 32'h8000_000F);
        @(negedge clk);
        hi = 0;
        for (int k = 0; k < 2000; k++) begin
            if (k == 400) begin
                addr = 3'd3; wdata = 32'h0064_00C8; wr = 1'b1;
            end else begin
                wr = 1'b0;
            end
            hi += int'(led[2]);
            @(negedge clk);
        end
        wr = 1'b0;
        check32("ch2_old_period", hi, 1000);
        count_high(2, 800, hi);
        check32("ch2_new_period", hi, 400);

        // Disable/invert, then RESTART phase alignment
        bus_wr(3'd0, 32'h0002_0005);
        repeat (3) @(negedge clk);
        check32("dis_inv_led1", {31'b0, led[1]}, 32'd1);
        check32("dis_led3", {31'b0, led[3]}, 32'd0);
        repeat (200) @(negedge clk);
        bus_wr(3'd0, 32'h8000_000F);
        @(negedge clk);
        check32("restart_align", {28'b0, led}, 32'hF);

        // Bus corner cases
        rd_chk(3'd5, 32'h0, "rd_oob5");
        rd_chk(3'd7, 32'h0, "rd_oob7");
        addr = 3'd0; rd = 1'b1;
        @(negedge clk);
        check32("b2b_0_valid", {31'b0, rdv}, 32'd1);
        check32("b2b_0", rdata, 32'h0000_000F);
        addr = 3'd1;
        @(negedge clk);
        rd = 1'b0;
        check32("b2b_1_valid", {31'b0, rdv}, 32'd1);
        check32("b2b_1", rdata, 32'h0005_0010);
        addr = 3'd2; rd = 1'b1; wr = 1'b1; wdata = 32'h1234_0040;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        check32("rw_same_old", rdata, 32'h0040_0030);
        rd_chk(3'd2, 32'h1234_0040, "rw_same_new");
        bus_wr(3'd6, 32'hDEAD_BEEF);
        rd_chk(3'd1, 32'h0005_0010, "oob_write_ignored");
        bus_wr(3'd0, 32'hFFFF_FFFF);
        rd_chk(3'd0, 32'h000F_000F, "ctrl_impl_bits");
        bus_wr(3'd0, 32'h0000_000F);

        // Randomized bus traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int r;
            r     = $urandom_range(0, 99);
            addr  = AW'($urandom_range(0, 7));
            rd    = (r < 25);
            wr    = (r >= 96);
            wdata = (addr == 0) ? $urandom
                                : {8'h00, 8'($urandom), 8'h00, 8'($urandom)};
            @(negedge clk);
        end
        rd = 1'b0; wr = 1'b0;
        repeat (50) @(negedge clk);

        // Reset in the middle of operation overrides a concurrent read and write
        bus_wr(3'd1, 32'h0011_0045);
        srst = 1'b1; rd = 1'b1; wr = 1'b1; addr = 3'd2; wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        check32("midrst_led", {28'b0, led}, 32'h0);
        check32("midrst_rdv", {31'b0, rdv}, 32'h0);
        srst = 1'b0;
        rd_chk(3'd1, 32'h00FA_01F4, "midrst_ch0");
        rd_chk(3'd2, 32'h00FA_01F4, "midrst_ch1");
        rd_chk(3'd0, 32'h0000_000F, "midrst_ctrl");
        count_high(0, 2000, hi);
        check32("midrst_ch0_high", hi, 1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pwm_multi.md
Name: led_pwm_multi

Overview:
- Multi-channel successor of the single-LED square-wave flicker block.
- Drives LED_CNT LEDs, each with its own period and on-time (duty) in milliseconds, plus per-channel enable and output invert.
- Includes its own Avalon-MM pipelined slave register file, so no external regfile is needed.
- Sits on the HPS/FPGA lightweight bus next to the other board-control peripherals.

Parameters:
- CLOCK_FREQ_MHZ, 25, clk_i frequency in MHz.
- CLKS_PER_MS, CLOCK_FREQ_MHZ*1000, clocks per millisecond tick; overridable for simulation.
- LED_CNT, 4, number of LED channels (1..16).
- PERIOD_MIN_MS, 32, lower clamp on the effective period.
- ADDR_W, $clog2(LED_CNT+1), Avalon address width.

Ports:
- clk_i  in  1  system clock.
- srst_i  in  1  synchronous reset, active-high.
- amm_address_i  in  ADDR_W  word address.
- amm_writedata_i  in  32  write data.
- amm_read_i  in  1  read strobe.
- amm_write_i  in  1  write strobe.
- amm_readdata_o  out  32  read data.
- amm_readdatavalid_o  out  1  read data valid.
- amm_waitrequest_o  out  1  always 0.
- led_o  out  LED_CNT  LED drive, bit i = channel i.

Behaviour:
- Interface: one clock, clk_i; reset srst_i is synchronous and active-high.
- Register map:
  - Addr 0 CTRL: [15:0] enable per channel; [31:16] invert per channel (only bits up to LED_CNT-1 are implemented, others read 0); bit 31 write-only RESTART strobe, reads 0. When LED_CNT=16, bit 31 serves as RESTART on write and invert[15] is not writable.
  - Addr 1+i CHi: [15:0] period_ms, [31:16] on_ms.
- Reset values:
  - CTRL enable = all ones, invert = 0; every CHi period = 500, on = 250.
  - led_o = 0, amm_readdata_o = 0, amm_readdatavalid_o = 0, prescaler and all channel counters = 0.
- Avalon handshake:
  - waitrequest is held at 0.
  - A read in cycle N gives readdatavalid = 1 with data in cycle N+1, for exactly one cycle per read; back-to-back reads are pipelined.
  - A read and a write to the same address in the same cycle return the old value.
  - Addresses > LED_CNT: writes are ignored; reads return 0 and still assert readdatavalid.
- ms tick:
  - The prescaler counts 0..CLKS_PER_MS-1 and wraps.
  - tick = 1 for one clock when prescaler == CLKS_PER_MS-1.
- Shadow registers, per channel:
  - eff_period = max(period_ms, PERIOD_MIN_MS); eff_on = min(on_ms, eff_period).
  - Both are latched into shadow registers only at period wrap, on reset, or on RESTART.
  - A register write mid-period never truncates or stretches the current period.
- Channel counter, per channel (16-bit):
  - On tick: if cnt == shadow_period-1, then cnt <= 0 and the shadow registers reload; else cnt++.
  - When enable = 0, cnt is held at 0 and the shadow registers reload every cycle.
- Output, registered, one clock after the counter:
  - raw = enable & (cnt < shadow_on).
  - led_o[i] = raw ^ invert[i].
  - on_ms = 0 gives a constantly inactive LED; on_ms >= eff_period gives a constantly active LED.
  - A disabled channel outputs invert[i].
- RESTART:
  - Write CTRL with bit 31 = 1. The enable and invert fields from the same write take effect at the same time.
  - In the next cycle the prescaler and all channel counters clear to 0 and all shadow registers reload, which phase-aligns all channels.
  - Writing CTRL without bit 31 does not restart.
- Arithmetic: all comparisons are unsigned 16-bit; counters never exceed shadow_period-1, so there is no wrap past 0xFFFF.
- Reset mid-operation: srst_i overrides any in-flight read (no readdatavalid the next cycle) and any write in the same cycle.

Test Plan:
1. CLKS_PER_MS = 4, LED_CNT = 4, reset released -> every led_o bit is high for 250 ticks (1000 clk) and low for 250 ticks, repeating; a read of addr 1 returns 0x00FA_01F4 one cycle after amm_read_i.
2. Write CH0 = 0x0005_0010 (period 16, on 5) -> effective period 32 ms with 5 ms high; write CH1 = 0x0040_0030 -> channel 1 stays high continuously.
3. Write CH2 = 0x0064_00C8 at tick 100 of a 500-tick period -> the current period completes with 500/250 timing; the next period is 200/100.
4. Write CTRL = 0x0002_0005 -> led_o[1] = 1 constant (disabled, inverted), led_o[3] = 0 constant, channels 0 and 2 keep running; then write 0x8000_000F -> all counters clear and all four channels rise together 2 clocks later.
5. Read addr LED_CNT+1 -> readdatavalid = 1 with data 0; back-to-back reads of addr 0 and 1 -> two consecutive valid cycles carrying the correct data in order.
6. Assert srst_i mid-period after register writes -> all registers return to reset values, led_o = 0 in the same clock edge, and timing restarts from phase 0.
